// File: rtl/sdram_client_responder.sv
// Memory-backed stand-in for the SDRAM controller user interface (activate/CAS/burst/refresh timing).
// Latency: accept + act_latency cycles to first write word; a read adds cas_latency more; burst words run back to back.
// Backpressure: level requests are accepted only in IDLE, and the client holds a request until it sees write_flag/read_flag.
module sdram_client_responder #(
    parameter int   sdram_col_width  = 10,
    parameter int   sdram_row_width  = 13,
    parameter int   sdram_bank_width = 2,
    parameter int   sdram_data_width = 16,
    parameter int   mem_addr_width   = 12,
    parameter int   act_latency      = 3,
    parameter int   cas_latency      = 2,
    parameter int   refresh_interval = 780,
    parameter int   refresh_cycles   = 7,
    parameter logic no_refresh       = 1'b0
) (
    input  logic                                                        CLK,
    input  logic                                                        reset,
    input  logic [sdram_bank_width+sdram_row_width+sdram_col_width-1:0] address,
    input  logic [sdram_col_width-1:0]                                  access_num,
    input  logic [sdram_data_width-1:0]                                 data_in,
    output logic [sdram_data_width-1:0]                                 data_out,
    input  logic                                                        write_request,
    input  logic                                                        read_request,
    output logic                                                        write_flag,
    output logic                                                        read_flag,
    output logic                                                        idle
);

    localparam int ADDR_W = sdram_bank_width + sdram_row_width + sdram_col_width;
    localparam int COL_W  = sdram_col_width;
    localparam int CNT_W  = (COL_W > 16) ? COL_W : 16;
    localparam int REF_W  = (refresh_interval > 2) ? $clog2(refresh_interval) : 1;

    localparam logic [CNT_W-1:0] ACT_LOAD = CNT_W'(act_latency - 1);
    localparam logic [CNT_W-1:0] CAS_LOAD = CNT_W'((cas_latency > 0) ? cas_latency - 1 : 0);
    localparam logic [CNT_W-1:0] REF_LOAD = CNT_W'(refresh_cycles - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(refresh_interval - 1);
    localparam logic [REF_W-1:0] REF_ONE  = REF_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVATE,
        S_WRITE,
        S_CAS_WAIT,
        S_READ,
        S_RECOVER,
        S_REFRESH
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            w_cnt_nxt;
    logic [ADDR_W-1:0]           r_addr;
    logic [COL_W-1:0]            r_len;
    logic                        r_is_wr;
    logic [REF_W-1:0]            r_ref_cnt;
    logic                        r_ref_pend;
    logic                        w_accept;
    logic                        w_accept_wr;
    logic                        w_ref_done;
    logic                        w_wr_xfer;
    logic                        w_rd_xfer;
    logic [mem_addr_width-1:0]   w_idx;
    logic [COL_W-1:0]            w_len_acc;
    logic [CNT_W-1:0]            w_len_load;
    logic                        w_unused_addr_bits;

    // Backing store: never reset, so contents survive a mid-burst reset.
    logic [sdram_data_width-1:0] r_mem [0:(1<<mem_addr_width)-1];

    // Only the low bits of {bank,row,col} index the array; the rest are kept for clarity.
    assign w_idx              = r_addr[mem_addr_width-1:0];
    assign w_unused_addr_bits = ^r_addr;
    assign w_len_acc          = (access_num == '0) ? COL_ONE : access_num;
    assign w_len_load         = CNT_W'(r_len) - CNT_ONE;
    assign w_wr_xfer          = (r_state == S_WRITE);
    assign w_rd_xfer          = (w_state_nxt == S_READ);

    // Next-state logic: one shared down-counter times every multi-cycle state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_accept_wr = 1'b0;
        w_ref_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ref_pend) begin
                    w_state_nxt = S_REFRESH;
                    w_cnt_nxt   = REF_LOAD;
                end else if (write_request) begin
                    w_state_nxt = S_ACTIVATE;
                    w_cnt_nxt   = ACT_LOAD;
                    w_accept    = 1'b1;
                    w_accept_wr = 1'b1;
                end else if (read_request) begin
                    w_state_nxt = S_ACTIVATE;
                    w_cnt_nxt   = ACT_LOAD;
                    w_accept    = 1'b1;
                end
            end
            S_ACTIVATE: begin
                if (r_cnt == '0) begin
                    if (r_is_wr) begin
                        w_state_nxt = S_WRITE;
                        w_cnt_nxt   = w_len_load;
                    end else if (cas_latency == 0) begin
                        w_state_nxt = S_READ;
                        w_cnt_nxt   = w_len_load;
                    end else begin
                        w_state_nxt = S_CAS_WAIT;
                        w_cnt_nxt   = CAS_LOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_CAS_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_READ;
                    w_cnt_nxt   = w_len_load;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_WRITE, S_READ: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RECOVER;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_RECOVER: begin
                w_state_nxt = S_IDLE;
            end
            S_REFRESH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_ref_done  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counter and registered status flags; flags mirror the state being entered.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            write_flag <= 1'b0;
            read_flag  <= 1'b0;
            idle       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            write_flag <= (w_state_nxt == S_WRITE);
            read_flag  <= (w_state_nxt == S_READ);
            idle       <= (w_state_nxt == S_IDLE);
        end
    end

    // Transaction context: latch on accept, step the column (wrapping within the row) per transfer.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_addr   <= '0;
            r_len    <= COL_ONE;
            r_is_wr  <= 1'b0;
            data_out <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= address;
                r_len   <= w_len_acc;
                r_is_wr <= w_accept_wr;
            end else if (w_wr_xfer || w_rd_xfer) begin
                r_addr[COL_W-1:0] <= r_addr[COL_W-1:0] + COL_ONE;
            end
            if (w_rd_xfer) begin
                data_out <= r_mem[w_idx];
            end
        end
    end

    // Write port: one word per write_flag cycle at the current column.
    always_ff @(posedge CLK) begin
        if (w_wr_xfer) begin
            r_mem[w_idx] <= data_in;
        end
    end

    // Refresh timer: a wrap raises pending (extra wraps are absorbed), cleared when REFRESH completes.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_ref_cnt  <= '0;
            r_ref_pend <= 1'b0;
        end else if (no_refresh) begin
            r_ref_cnt  <= '0;
            r_ref_pend <= 1'b0;
        end else begin
            if (r_ref_cnt == REF_LAST) begin
                r_ref_cnt  <= '0;
                r_ref_pend <= 1'b1;
            end else begin
                r_ref_cnt <= r_ref_cnt + REF_ONE;
                if (w_ref_done) begin
                    r_ref_pend <= 1'b0;
                end
            end
        end
    end

endmodule
